apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave_pkg.sv | 16 +
 rtl/apb_reg_slave_if.sv | 34 +++
 rtl/apb_reg_slave_wait_gen.sv | 30 +++
 rtl/apb_reg_slave.sv | 143 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_reg_slave_pkg.sv
// Shared definitions for the APB register completer: FSM states, ID constant,
// register indices and wait-counter width.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] APB_SLV_ID = 32'hA9B0_0001;

  localparam int unsigned CTRL_IDX = 0;
  localparam int unsigned ID_IDX   = 1;
  localparam int unsigned WAIT_W   = 4;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB completer-side bus bundle. PSLVERR exists only when APB_SLV_PSLVERR_EN
// is defined.
interface apb_reg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY_o;
`ifdef APB_SLV_PSLVERR_EN
  logic                  PSLVERR;
`endif

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY_o
`ifdef APB_SLV_PSLVERR_EN
    , input PSLVERR
`endif
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY_o
`ifdef APB_SLV_PSLVERR_EN
    , output PSLVERR
`endif
  );

endinterface

// File: rtl/apb_reg_slave_wait_gen.sv
// Loadable wait-state down-counter; o_ready_nxt is the PREADY value for the
// next cycle, valid on both load and decrement cycles.
module apb_wait_gen
  import apb_pkg::*;
#(
  parameter int unsigned W = WAIT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_ready_nxt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_ready_nxt = i_load ? (i_load_val == '0) : (r_cnt == W'(1));

endmodule

// File: rtl/apb_reg_slave.sv
// APB register completer: CTRL (wait states), read-only ID, scratch registers.
// Optional PSLVERR response enabled by defining APB_SLV_PSLVERR_EN.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input logic            PCLK,
  input logic            PRESETn,
  apb_reg_slave_if.slave apb
);

  localparam int unsigned           IDX_W  = $clog2(NUM_REGS);
  localparam logic [DATA_WIDTH-1:0] ID_VAL = DATA_WIDTH'(APB_SLV_ID);
  localparam logic [IDX_W-1:0]      ID_I   = IDX_W'(ID_IDX);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_setup;
  logic                  w_dec;
  logic                  w_ready_nxt;
  logic [WAIT_W-1:0]     w_wait;
  logic [IDX_W-1:0]      w_addr_idx;
  logic [IDX_W-1:0]      w_cur_idx;
  logic                  w_cur_write;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_ok;
  logic                  w_unused;

  assign w_addr_idx  = apb.PADDR[IDX_W+1:2];
  assign w_setup     = (r_state == IDLE) && apb.PSEL && !apb.PENABLE;
  assign w_dec       = (r_state == ACCESS) && apb.PSEL && !r_ready;
  assign w_wait      = r_regs[CTRL_IDX][WAIT_W-1:0];
  // Decode from the live bus during SETUP, from the latched copy afterwards.
  assign w_cur_idx   = (r_state == IDLE) ? w_addr_idx : r_idx;
  assign w_cur_write = (r_state == IDLE) ? apb.PWRITE : r_write;

`ifdef APB_SLV_PSLVERR_EN
  logic r_oor;
  logic r_slverr;
  logic w_addr_oor;
  logic w_cur_oor;
  logic w_cur_err;

  assign w_addr_oor  = |apb.PADDR[ADDR_WIDTH-1:IDX_W+2];
  assign w_cur_oor   = (r_state == IDLE) ? w_addr_oor : r_oor;
  assign w_cur_err   = w_cur_oor || (w_cur_write && (w_cur_idx == ID_I));
  assign apb.PSLVERR = r_slverr;
  assign w_unused    = ^apb.PADDR[1:0];
`else
  assign w_unused    = ^{apb.PADDR[ADDR_WIDTH-1:IDX_W+2], apb.PADDR[1:0], w_cur_write};
`endif

  always_comb begin
    w_rd_data = (w_cur_idx == ID_I) ? ID_VAL : r_regs[w_cur_idx];
`ifdef APB_SLV_PSLVERR_EN
    if (w_cur_oor) w_rd_data = '0;
`endif
  end

  always_comb begin
    w_wr_ok = r_write && (r_idx != ID_I);
`ifdef APB_SLV_PSLVERR_EN
    if (r_oor) w_wr_ok = 1'b0;
`endif
  end

  apb_wait_gen #(.W(WAIT_W)) u_wait_gen (
    .i_clk       (PCLK),
    .i_rst_n     (PRESETn),
    .i_load      (w_setup),
    .i_dec       (w_dec),
    .i_load_val  (w_wait),
    .o_ready_nxt (w_ready_nxt)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef APB_SLV_PSLVERR_EN
      r_oor    <= 1'b0;
      r_slverr <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_idx   <= w_addr_idx;
            r_write <= apb.PWRITE;
            r_ready <= w_ready_nxt;
            if (w_ready_nxt && !apb.PWRITE) r_rdata <= w_rd_data;
`ifdef APB_SLV_PSLVERR_EN
            r_oor    <= w_addr_oor;
            r_slverr <= w_ready_nxt && w_cur_err;
`endif
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
`ifdef APB_SLV_PSLVERR_EN
            r_slverr <= 1'b0;
`endif
          end else if (r_ready) begin
            if (apb.PENABLE) begin
              if (w_wr_ok) r_regs[r_idx] <= apb.PWDATA;
              r_state <= IDLE;
              r_ready <= 1'b0;
`ifdef APB_SLV_PSLVERR_EN
              r_slverr <= 1'b0;
`endif
            end
          end else begin
            r_ready <= w_ready_nxt;
            if (w_ready_nxt && !r_write) r_rdata <= w_rd_data;
`ifdef APB_SLV_PSLVERR_EN
            r_slverr <= w_ready_nxt && w_cur_err;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign apb.PREADY_o = r_ready;
  assign apb.PRDATA   = r_rdata;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: reset, ID, wait states, abort, reset
// mid-transfer, back-to-back and out-of-range addressing.
module tb_apb_reg_slave;
  import apb_pkg::*;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   failures;

  apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Called #1 after an edge; returns #1 after the completion edge with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int acc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    acc = 1;
    while (bus.PREADY_o !== 1'b1 && acc < 40) begin
      @(posedge PCLK); #1;
      acc++;
    end
    rdata = bus.PRDATA;
`ifdef APB_SLV_PSLVERR_EN
    err = bus.PSLVERR;
`else
    err = 1'b0;
`endif
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if (bus.PREADY_o !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", bus.PREADY_o); end
    checks++;
    if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA); end
`ifdef APB_SLV_PSLVERR_EN
    checks++;
    if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", bus.PSLVERR); end
`endif
    PRESETn = 1'b1;
  endtask

  task automatic test_id_read();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b0, 32'h4, 32'h0, rd, err, acc);
    checks++;
    if (acc !== 1) begin failures++; $display("FAIL id_read_cycles got=%0d exp=1", acc); end
    checks++;
    if (rd !== 32'hA9B0_0001) begin failures++; $display("FAIL id_read_data got=%h exp=a9b00001", rd); end
`ifdef APB_SLV_PSLVERR_EN
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL id_read_err got=%b exp=0", err); end
`endif
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b1, 32'h0, 32'h3, rd, err, acc);
    checks++;
    if (acc !== 1) begin failures++; $display("FAIL ctrl_write_cycles got=%0d exp=1", acc); end
    xfer(1'b1, 32'h14, 32'hDEAD_BEEF, rd, err, acc);
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL wait_write_cycles got=%0d exp=4", acc); end
    xfer(1'b0, 32'h14, 32'h0, rd, err, acc);
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL wait_read_cycles got=%0d exp=4", acc); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wait_read_data got=%h exp=deadbeef", rd); end
    xfer(1'b0, 32'h0, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h3) begin failures++; $display("FAIL ctrl_readback got=%h exp=3", rd); end
  endtask

  task automatic test_id_write();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b1, 32'h4, 32'h1234_5678, rd, err, acc);
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL id_write_cycles got=%0d exp=4", acc); end
`ifdef APB_SLV_PSLVERR_EN
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL id_write_err got=%b exp=1", err); end
    checks++;
    if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL id_write_err_clear got=%b exp=0", bus.PSLVERR); end
`endif
    xfer(1'b0, 32'h4, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'hA9B0_0001) begin failures++; $display("FAIL id_after_write got=%h exp=a9b00001", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b1, 32'hC, 32'h1111_2222, rd, err, acc);
    xfer(1'b1, 32'h8, 32'h0000_2222, rd, err, acc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'hC; bus.PWDATA = 32'hAA;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    checks++;
    if (bus.PREADY_o !== 1'b0) begin failures++; $display("FAIL abort_pready got=%b exp=0", bus.PREADY_o); end
    checks++;
    if (dut.r_state !== IDLE) begin failures++; $display("FAIL abort_state got=%b exp=IDLE", dut.r_state); end
    xfer(1'b0, 32'hC, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h1111_2222) begin failures++; $display("FAIL abort_reg3 got=%h exp=11112222", rd); end
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL abort_next_cycles got=%0d exp=4", acc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b1, 32'h0, 32'h5, rd, err, acc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h8; bus.PWDATA = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    checks++;
    if (bus.PREADY_o !== 1'b0) begin failures++; $display("FAIL rstmid_wait got=%b exp=0", bus.PREADY_o); end
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    checks++;
    if (bus.PREADY_o !== 1'b0) begin failures++; $display("FAIL rstmid_pready got=%b exp=0", bus.PREADY_o); end
    checks++;
    if (dut.r_state !== IDLE) begin failures++; $display("FAIL rstmid_state got=%b exp=IDLE", dut.r_state); end
    PRESETn = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    xfer(1'b0, 32'h8, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_reg2 got=%h exp=0", rd); end
    checks++;
    if (acc !== 1) begin failures++; $display("FAIL rstmid_cycles got=%0d exp=1", acc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int acc;
    logic [31:0] exp;
    for (int i = 2; i < 16; i++) begin
      xfer(1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), rd, err, acc);
      checks++;
      if (acc !== 1) begin failures++; $display("FAIL b2b_write_cycles reg%0d got=%0d exp=1", i, acc); end
    end
    checks++;
    if (bus.PREADY_o !== 1'b0) begin failures++; $display("FAIL b2b_pready_low got=%b exp=0", bus.PREADY_o); end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, rd, err, acc);
      if (i == 0)      exp = 32'h0;
      else if (i == 1) exp = 32'hA9B0_0001;
      else             exp = 32'hC0DE_0000 | 32'(i);
      checks++;
      if (rd !== exp || acc !== 1) begin
        failures++;
        $display("FAIL b2b_readback reg%0d got=%h/%0d exp=%h/1", i, rd, acc, exp);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int acc;
    xfer(1'b1, 32'h108, 32'h0BAD_F00D, rd, err, acc);
`ifdef APB_SLV_PSLVERR_EN
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL oor_write_err got=%b exp=1", err); end
    xfer(1'b0, 32'h8, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'hC0DE_0002) begin failures++; $display("FAIL oor_write_dropped got=%h exp=c0de0002", rd); end
    xfer(1'b0, 32'h108, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL oor_read got=%h/%b exp=0/1", rd, err); end
`else
    xfer(1'b0, 32'h8, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL oor_alias_write got=%h exp=0badf00d", rd); end
    xfer(1'b0, 32'h108, 32'h0, rd, err, acc);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL oor_alias_read got=%h exp=0badf00d", rd); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_id_read();
    test_wait_states();
    test_id_write();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
